// File: rtl/vx_muldiv_unit_if.sv
// Request/response bundle for vx_muldiv_unit.
//   master: requester side (drives operands, flush and out_ready)
//   slave : the unit (drives in_ready and the result channel)
interface vx_muldiv_unit_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_WIDTH = 8
);
  logic                 in_flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_op;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_result;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/vx_muldiv_unit.sv
// Multi-cycle RV M-extension unit: MUL/MULH/MULHSU/MULHU in MUL_LATENCY
// cycles, DIV/DIVU/REM/REMU via a radix-2 restoring divider (WIDTH+1 cycles),
// divide-by-zero and signed overflow answered in one cycle.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - slave side of vx_muldiv_unit_if (request, flush, result channel)
module vx_muldiv_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned TAG_WIDTH   = 8,
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  vx_muldiv_unit_if.slave     bus
);

  localparam int unsigned CNT_MAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     result_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [2:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [WIDTH-1:0]     quo_q, rem_q, dvs_q;
  logic [CNT_W-1:0]     cnt_q;

  // Operand view: live inputs while idle (for one-cycle results), captured copies afterwards
  logic [2:0]         op_s;
  logic [WIDTH-1:0]   a_s, b_s;
  logic               is_div, is_rem, div_signed, a_neg, b_neg, b_zero, ovf;
  logic [WIDTH-1:0]   a_mag, b_mag, special_res;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0]   mul_res;
  logic [WIDTH:0]     shifted, diff;
  logic               take;
  logic [WIDTH-1:0]   quo_d, rem_d, div_res;

  always_comb begin
    op_s = op_q;
    a_s  = a_q;
    b_s  = b_q;
    if (state_q == S_IDLE) begin
      op_s = bus.in_op;
      a_s  = bus.in_a;
      b_s  = bus.in_b;
    end

    is_div     = op_s[2];
    is_rem     = op_s[1];
    div_signed = ~op_s[0];
    a_neg      = div_signed & a_s[WIDTH-1];
    b_neg      = div_signed & b_s[WIDTH-1];
    a_mag      = a_neg ? ('0 - a_s) : a_s;
    b_mag      = b_neg ? ('0 - b_s) : b_s;
    b_zero     = (b_s == '0);
    ovf        = div_signed & (a_s == MIN_NEG) & (b_s == '1);

    special_res = a_s;
    if (b_zero)      special_res = is_rem ? a_s : '1;
    else if (is_rem) special_res = '0;

    // MULH: both signed; MULHSU: a signed only; MUL/MULHU: zero-extend (low half identical)
    a_ext = {{WIDTH{1'b0}}, a_s};
    b_ext = {{WIDTH{1'b0}}, b_s};
    if (op_s == 3'd1 || op_s == 3'd2) a_ext = {{WIDTH{a_s[WIDTH-1]}}, a_s};
    if (op_s == 3'd1)                 b_ext = {{WIDTH{b_s[WIDTH-1]}}, b_s};
    prod    = a_ext * b_ext;
    mul_res = (op_s == 3'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];

    // One restoring step: shift next dividend bit into the partial remainder
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    take    = ~diff[WIDTH];
    rem_d   = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], take};

    // Sign fix-up applied to the final step's output
    if (is_rem) div_res = a_neg ? ('0 - rem_d) : rem_d;
    else        div_res = (a_neg ^ b_neg) ? ('0 - quo_d) : quo_d;
  end

  // Control FSM plus datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      tag_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
    end else if (bus.in_flush) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q       <= bus.in_op;
            a_q        <= bus.in_a;
            b_q        <= bus.in_b;
            tag_q      <= bus.in_tag;
            in_ready_q <= 1'b0;
            if (!is_div) begin
              if (MUL_LATENCY == 1) begin
                result_q    <= mul_res;
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end else begin
                cnt_q   <= CNT_W'(MUL_LATENCY) - CNT_W'(2);
                state_q <= S_MUL;
              end
            end else if (b_zero || ovf) begin
              result_q    <= special_res;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              quo_q   <= a_mag;
              rem_q   <= '0;
              dvs_q   <= b_mag;
              cnt_q   <= CNT_W'(WIDTH);
              state_q <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            result_q    <= mul_res;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DIV: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_q    <= div_res;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign bus.out_tag    = tag_q;

endmodule

// File: tb/tb_vx_muldiv_unit.sv
// Directed bench for vx_muldiv_unit: a 32-bit/MUL_LATENCY=2 instance and a
// 16-bit/MUL_LATENCY=1 instance, checked against hand-computed results.
// Latency is counted as the number of rising edges from the acceptance edge
// (inclusive) up to the edge after which out_valid is first seen high.
module tb_vx_muldiv_unit;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;

  vx_muldiv_unit_if #(.WIDTH(32), .TAG_WIDTH(8)) bus32 ();
  vx_muldiv_unit_if #(.WIDTH(16), .TAG_WIDTH(8)) bus16 ();

  vx_muldiv_unit #(.WIDTH(32), .TAG_WIDTH(8), .MUL_LATENCY(2)) u_dut32 (
    .clk(clk), .reset(reset), .bus(bus32)
  );
  vx_muldiv_unit #(.WIDTH(16), .TAG_WIDTH(8), .MUL_LATENCY(1)) u_dut16 (
    .clk(clk), .reset(reset), .bus(bus16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag);
    if (sel == 32) begin
      bus32.in_valid = v; bus32.in_op = op; bus32.in_a = a; bus32.in_b = b; bus32.in_tag = tag;
    end else begin
      bus16.in_valid = v; bus16.in_op = op; bus16.in_a = a[15:0]; bus16.in_b = b[15:0];
      bus16.in_tag = tag;
    end
  endtask

  task automatic set_ctl(input int sel, input logic flush, input logic ordy);
    if (sel == 32) begin bus32.in_flush = flush; bus32.out_ready = ordy; end
    else           begin bus16.in_flush = flush; bus16.out_ready = ordy; end
  endtask

  function automatic logic vld(input int sel);
    return (sel == 32) ? bus32.out_valid : bus16.out_valid;
  endfunction
  function automatic logic rdy(input int sel);
    return (sel == 32) ? bus32.in_ready : bus16.in_ready;
  endfunction
  function automatic logic [31:0] res(input int sel);
    return (sel == 32) ? bus32.out_result : {16'h0, bus16.out_result};
  endfunction
  function automatic logic [7:0] otag(input int sel);
    return (sel == 32) ? bus32.out_tag : bus16.out_tag;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then scramble the inputs
  task automatic issue(input int sel, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [7:0] tag);
    drive(sel, 1'b1, op, a, b, tag);
    tick();
    drive(sel, 1'b0, 3'd7, 32'hDEADBEEF, 32'hCAFEF00D, 8'h5A);
  endtask

  task automatic wait_valid(input int sel, output int lat);
    lat = 1;
    while (!vld(sel) && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic op_check(input int sel, input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
    logic [7:0] tg;
    int lat;
    tg = 8'($urandom_range(1, 255));
    issue(sel, op, a, b, tg);
    wait_valid(sel, lat);
    check({name, ".lat"}, 64'(lat), 64'(exp_lat));
    check({name, ".res"}, 64'(res(sel)), 64'(exp));
    check({name, ".tag"}, 64'(otag(sel)), 64'(tg));
    set_ctl(sel, 1'b0, 1'b1);
    tick();
    set_ctl(sel, 1'b0, 1'b0);
    check({name, ".drain"}, 64'({vld(sel), rdy(sel)}), 64'(2'b01));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic seen;
    int   lat;

    reset = 1'b0;
    drive(32, 1'b0, 3'd0, 32'h0, 32'h0, 8'h0);
    drive(16, 1'b0, 3'd0, 32'h0, 32'h0, 8'h0);
    set_ctl(32, 1'b0, 1'b0);
    set_ctl(16, 1'b0, 1'b0);
    repeat (2) tick();
    check("rst.out_valid",  64'(vld(32)),  64'd0);
    check("rst.out_result", 64'(res(32)),  64'd0);
    check("rst.out_tag",    64'(otag(32)), 64'd0);
    check("rst.in_ready",   64'(rdy(32)),  64'd1);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Multiplies, 32-bit, latency 2
    op_check(32, "mul",    OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2);
    op_check(32, "mulh",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 2);
    op_check(32, "mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 2);
    op_check(32, "mulhu",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
    // Divides, 32-bit, WIDTH+1 cycles
    op_check(32, "div",    OP_DIV,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 33);
    op_check(32, "rem",    OP_REM,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 33);
    op_check(32, "divu",   OP_DIVU,   32'd100,      32'd7,        32'd14,       33);
    op_check(32, "remu",   OP_REMU,   32'd100,      32'd7,        32'd2,        33);
    op_check(32, "div_nb", OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    op_check(32, "rem_nb", OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33);
    // Special cases, one cycle
    op_check(32, "div_z",  OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
    op_check(32, "remu_z", OP_REMU,   32'h1234,     32'd0,        32'h1234,     1);
    op_check(32, "div_ov", OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    op_check(32, "rem_ov", OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Backpressure: result held while out_ready is low
    issue(32, OP_DIVU, 32'd100, 32'd7, 8'hA5);
    wait_valid(32, lat);
    check("bp.lat", 64'(lat), 64'd33);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp.hold", 64'({vld(32), rdy(32), res(32), otag(32)}),
                       64'({1'b1, 1'b0, 32'd14, 8'hA5}));
    end
    set_ctl(32, 1'b0, 1'b1);
    tick();
    set_ctl(32, 1'b0, 1'b0);
    check("bp.release", 64'({vld(32), rdy(32)}), 64'(2'b01));
    op_check(32, "bp.next", OP_MULHU, 32'h00010000, 32'h00030000, 32'd3, 2);

    // Flush during divide iteration 10
    issue(32, OP_DIV, 32'd1000, 32'd3, 8'h11);
    repeat (9) tick();
    set_ctl(32, 1'b1, 1'b0);
    tick();
    set_ctl(32, 1'b0, 1'b0);
    check("flush_div.state", 64'({vld(32), rdy(32)}), 64'(2'b01));
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (vld(32)) seen = 1'b1;
    end
    check("flush_div.no_valid", 64'(seen), 64'd0);
    op_check(32, "flush.mul", OP_MUL, 32'd3, 32'd5, 32'd15, 2);

    // Flush together with out_ready in DONE drops the result
    issue(32, OP_MUL, 32'd6, 32'd7, 8'h22);
    wait_valid(32, lat);
    check("flush_done.res", 64'(res(32)), 64'd42);
    set_ctl(32, 1'b1, 1'b1);
    tick();
    set_ctl(32, 1'b0, 1'b0);
    check("flush_done.state", 64'({vld(32), rdy(32)}), 64'(2'b01));
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (vld(32)) seen = 1'b1;
    end
    check("flush_done.no_valid", 64'(seen), 64'd0);

    // Flush beats a simultaneous request (div-by-zero would otherwise finish next edge)
    drive(32, 1'b1, OP_DIVU, 32'd5, 32'd0, 8'h33);
    set_ctl(32, 1'b1, 1'b0);
    tick();
    drive(32, 1'b0, 3'd0, 32'h0, 32'h0, 8'h0);
    set_ctl(32, 1'b0, 1'b0);
    check("flush_acc.state", 64'({vld(32), rdy(32)}), 64'(2'b01));
    tick();
    check("flush_acc.idle", 64'({vld(32), rdy(32)}), 64'(2'b01));

    // Asynchronous reset mid-divide
    issue(32, OP_DIV, 32'hFFFFFF9C, 32'd7, 8'h44);
    repeat (5) tick();
    #3;
    reset = 1'b0;
    #1;
    check("arst.state",  64'({vld(32), rdy(32)}), 64'(2'b01));
    check("arst.result", 64'(res(32)), 64'd0);
    reset = 1'b1;
    tick();
    check("arst.after", 64'({vld(32), rdy(32)}), 64'(2'b01));
    op_check(32, "arst.div", OP_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33);

    // 16-bit instance, MUL_LATENCY = 1
    op_check(16, "w16.mul",    OP_MUL,    32'h0007, 32'hFFFD, 32'hFFEB, 1);
    op_check(16, "w16.mulh",   OP_MULH,   32'h8000, 32'h8000, 32'h4000, 1);
    op_check(16, "w16.mulhsu", OP_MULHSU, 32'hFFFF, 32'h0002, 32'hFFFF, 1);
    op_check(16, "w16.mulhu",  OP_MULHU,  32'hFFFF, 32'hFFFF, 32'hFFFE, 1);
    op_check(16, "w16.div",    OP_DIV,    32'hFFEC, 32'h0003, 32'hFFFA, 17);
    op_check(16, "w16.rem",    OP_REM,    32'hFFEC, 32'h0003, 32'hFFFE, 17);
    op_check(16, "w16.divu",   OP_DIVU,   32'd100,  32'd7,    32'd14,   17);
    op_check(16, "w16.remu",   OP_REMU,   32'd100,  32'd7,    32'd2,    17);
    op_check(16, "w16.div_z",  OP_DIV,    32'h0005, 32'h0000, 32'hFFFF, 1);
    op_check(16, "w16.remu_z", OP_REMU,   32'h1234, 32'h0000, 32'h1234, 1);
    op_check(16, "w16.div_ov", OP_DIV,    32'h8000, 32'hFFFF, 32'h8000, 1);
    op_check(16, "w16.rem_ov", OP_REM,    32'h8000, 32'hFFFF, 32'h0000, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/vx_muldiv_unit.md
Name: vx_muldiv_unit

Overview:
- Multi-cycle, parameterised successor to the single-cycle combinational ALU's M-extension path.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over a valid/ready handshake: one operation in flight at a time.
- Multiplies take a fixed, parameterised number of cycles; divides use an iterative radix-2 restoring divider.
- Sits in the execute stage beside the ALU. A tag is carried through so writeback can route the result; a flush aborts the in-flight operation.

Parameters:
- WIDTH, 32, operand/result width (>=8, even).
- TAG_WIDTH, 8, width of the opaque tag passed from input to output.
- MUL_LATENCY, 2, cycles from acceptance to out_valid for multiplies (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset: 0 resets, 1 runs.
- in_flush  in  1  synchronous abort of any operation held or in flight.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_a  in  WIDTH  operand 1 (rs1).
- in_b  in  WIDTH  operand 2 (rs2).
- in_tag  in  TAG_WIDTH  opaque tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  result.
- out_tag  out  TAG_WIDTH  tag captured with the request.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, out_valid=0, out_result=0, out_tag=0, counter=0. in_ready=1 after reset deasserts.
- FSM states:
  - IDLE: in_ready=1.
  - MUL, DIV, DONE: in_ready=0.
- Acceptance: in_valid & in_ready at a rising edge. Operands, op and tag are registered at that edge; later changes to in_* are ignored.
- IDLE -> MUL for op 0-3.
  - Full 2*WIDTH product.
  - Operand sign handling: MULH both signed; MULHSU a signed, b unsigned; MULHU both unsigned; MUL returns low WIDTH bits.
  - The counter counts MUL_LATENCY-1 further cycles, then -> DONE.
  - out_valid is high in the MUL_LATENCY-th cycle after the acceptance cycle.
- IDLE -> DIV for op 4-7, normal case.
  - Signed ops convert operands to magnitudes.
  - WIDTH restoring iterations, one per cycle.
  - Final quotient/remainder sign fix-up, then -> DONE.
  - out_valid is high in cycle WIDTH+1 after acceptance.
- Divide special cases bypass iteration: IDLE -> DONE directly, out_valid in cycle 1.
  - b==0: DIV/DIVU result all-ones; REM/REMU result = a.
  - Signed overflow (a = most-negative, b = -1, DIV/REM only): DIV result = a; REM result = 0.
- Sign rules: quotient negative iff signs differ (and b!=0); remainder takes the sign of the dividend.
- DONE: out_valid=1; out_result and out_tag held stable.
  - out_ready=1 at an edge -> IDLE and out_valid=0.
  - The earliest new acceptance is the following edge (no same-cycle turnaround).
- Flush: in_flush=1 at an edge -> IDLE and out_valid=0 from any state, discarding the result. Flush has priority over acceptance and over out_ready in the same cycle.
- Backpressure: the unit holds DONE indefinitely while out_ready=0.
- All arithmetic is internally 2*WIDTH or WIDTH+1 wide; no intermediate truncation before result selection.
- in_op, in_a, in_b and in_tag are don't-care while in_valid=0.

Test Plan:
1. WIDTH=32: MUL a=7, b=-3 -> out_result=0xFFFFFFEB, out_valid in cycle 2. MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHSU a=-1, b=2 -> 0xFFFFFFFF. MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE.
2. DIV a=-20, b=3 -> 0xFFFFFFFA (-6). REM same operands -> 0xFFFFFFFE (-2). DIVU a=100, b=7 -> 14. REMU same operands -> 2. out_valid in cycle 33 with out_tag equal to in_tag.
3. b=0: DIV -> 0xFFFFFFFF; REMU a=0x1234 -> 0x1234. Overflow: DIV a=0x80000000, b=-1 -> 0x80000000; REM same -> 0. All four complete in cycle 1.
4. Backpressure: out_ready=0 for 10 cycles after a DIVU completes -> out_valid/out_result/out_tag stable and in_ready=0. out_ready=1 -> IDLE next cycle; a second request accepted one edge later.
5. Flush at DIV iteration 10 -> out_valid never asserts and in_ready=1 next cycle. Next MUL 3*5 -> 15. Flush asserted together with out_ready in DONE -> result dropped.
6. reset driven low mid-DIV, asynchronously between edges -> out_valid=0 and in_ready=1 immediately. Repeat tests 1-3 with WIDTH=16, MUL_LATENCY=1: MUL results in cycle 1, DIV results in cycle 17.
